// File: rtl/fp_add_pkg.sv
// ============================================================================
//  Module      : fp_add_pkg
//  Description : Shared widths, constants and pipeline-register types for the
//                fp add/sub mantissa stage.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fp_add_pkg;

    localparam int FP_MAN_W = 24;
    localparam int FP_EXP_W = 8;

    localparam logic [FP_EXP_W-1:0] EXP_INF = '1;

    typedef struct packed {
        logic                sign;
        logic [FP_EXP_W-1:0] exp;
        logic [FP_MAN_W-2:0] frac;
    } fp32_t;

    // Stage-1 register: raw signed-magnitude sum with carry bit
    typedef struct packed {
        logic                sign;
        logic [FP_EXP_W-1:0] exp;
        logic [FP_MAN_W:0]   sum;
    } s1_t;

    // Stage-2 register: exp carries one extra bit so overflow stays visible
    typedef struct packed {
        logic                sign;
        logic [FP_EXP_W:0]   exp;
        logic [FP_MAN_W-1:0] man;
        logic                guard;
        logic                zero;
        logic                unf;
    } s2_t;

endpackage

`default_nettype wire

// File: rtl/lzc24.sv
// ============================================================================
//  Module      : lzc24
//  Description : Combinational leading-zero counter with all-zero flag.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lzc24 #(
    parameter int W     = 24,
    parameter int CNT_W = $clog2(W)
) (
    input  logic [W-1:0]     data_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             zero_o
);

    // Scan upward so the most significant set bit is the last one written
    always_comb begin
        cnt_o  = '0;
        zero_o = 1'b1;
        for (int i = 0; i < W; i++) begin
            if (data_i[i]) begin
                cnt_o  = CNT_W'(W - 1 - i);
                zero_o = 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mant_addsub_normalize.sv
// ============================================================================
//  Module      : mant_addsub_normalize
//  Description : 3-stage add/sub, normalise and IEEE-754 single pack stage.
//                Optional macro FP_ADD_ROUND_NEAREST_EN enables RNE rounding.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mant_addsub_normalize
    import fp_add_pkg::*;
#(
    parameter int MAN_W = FP_MAN_W,
    parameter int EXP_W = FP_EXP_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   op_sub,
    input  logic                   sign_a,
    input  logic                   sign_b,
    input  logic [EXP_W-1:0]       exp_max,
    input  logic [MAN_W-1:0]       al_man_a,
    input  logic [MAN_W-1:0]       al_man_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W-1:0] result,
    output logic                   flag_zero,
    output logic                   flag_ovf,
    output logic                   flag_unf
);

    localparam int LZ_W = $clog2(MAN_W);

    logic  s1_valid_q, s2_valid_q, out_valid_q;
    logic  out_en, s2_en, s1_en;
    s1_t   s1_d, s1_q;
    s2_t   s2_d, s2_q;
    fp32_t res_d, res_q;
    logic  zero_d, ovf_d, unf_d;
    logic  zero_q, ovf_q, unf_q;
    logic  eff_sub;
    logic [LZ_W-1:0]  lz;
    logic             lz_zero;
    logic [MAN_W-1:0] rnd_man;
    logic [EXP_W:0]   rnd_exp;
    logic             w_unused_bits;

    // A stage may load when it is empty or its content moves on this cycle
    assign out_en   = !out_valid_q || out_ready;
    assign s2_en    = !s2_valid_q || out_en;
    assign s1_en    = !s1_valid_q || s2_en;
    assign in_ready = s1_en && !rst;

    always_comb begin
        eff_sub   = sign_a ^ sign_b ^ op_sub;
        s1_d.exp  = exp_max;
        s1_d.sign = sign_a;
        if (!eff_sub) begin
            s1_d.sum = {1'b0, al_man_a} + {1'b0, al_man_b};
        end else if (al_man_a >= al_man_b) begin
            s1_d.sum = {1'b0, al_man_a} - {1'b0, al_man_b};
        end else begin
            s1_d.sum  = {1'b0, al_man_b} - {1'b0, al_man_a};
            s1_d.sign = sign_b ^ op_sub;
        end
        if (s1_d.sum == '0) s1_d.sign = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
        end else if (s1_en) begin
            s1_valid_q <= in_valid;
            if (in_valid) s1_q <= s1_d;
        end
    end

    lzc24 #(
        .W     (MAN_W),
        .CNT_W (LZ_W)
    ) u_lzc (
        .data_i (s1_q.sum[MAN_W-1:0]),
        .cnt_o  (lz),
        .zero_o (lz_zero)
    );

    // No subnormals: a shift that would drive exp to 0 or below flushes to +0
    always_comb begin
        s2_d      = '0;
        s2_d.sign = s1_q.sign;
        if (s1_q.sum[MAN_W]) begin
            s2_d.man   = s1_q.sum[MAN_W:1];
            s2_d.guard = s1_q.sum[0];
            s2_d.exp   = (EXP_W+1)'(s1_q.exp) + (EXP_W+1)'(1);
        end else if (lz_zero) begin
            s2_d.zero = 1'b1;
            s2_d.sign = 1'b0;
        end else if ({{(EXP_W-LZ_W){1'b0}}, lz} >= s1_q.exp) begin
            s2_d.unf  = 1'b1;
            s2_d.sign = 1'b0;
        end else begin
            s2_d.man = s1_q.sum[MAN_W-1:0] << lz;
            s2_d.exp = {1'b0, s1_q.exp - EXP_W'(lz)};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            s2_q       <= '0;
        end else if (s2_en) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) s2_q <= s2_d;
        end
    end

`ifdef FP_ADD_ROUND_NEAREST_EN
    logic [MAN_W:0] inc_man;

    always_comb begin
        inc_man = {1'b0, s2_q.man} + (MAN_W+1)'(s2_q.guard & s2_q.man[0]);
        rnd_man = inc_man[MAN_W-1:0];
        rnd_exp = s2_q.exp;
        if (inc_man[MAN_W]) begin
            rnd_man = {1'b1, {(MAN_W-1){1'b0}}};
            rnd_exp = s2_q.exp + (EXP_W+1)'(1);
        end
    end

    assign w_unused_bits = rnd_man[MAN_W-1];
`else
    assign rnd_man       = s2_q.man;
    assign rnd_exp       = s2_q.exp;
    assign w_unused_bits = ^{rnd_man[MAN_W-1], s2_q.guard};
`endif

    always_comb begin
        res_d  = '0;
        zero_d = s2_q.zero;
        unf_d  = s2_q.unf;
        ovf_d  = 1'b0;
        if (!(s2_q.zero || s2_q.unf)) begin
            res_d.sign = s2_q.sign;
            if (rnd_exp >= {1'b0, EXP_INF}) begin
                res_d.exp = EXP_INF;
                ovf_d     = 1'b1;
            end else begin
                res_d.exp  = rnd_exp[EXP_W-1:0];
                res_d.frac = rnd_man[MAN_W-2:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            res_q       <= '0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else if (out_en) begin
            out_valid_q <= s2_valid_q;
            if (s2_valid_q) begin
                res_q  <= res_d;
                zero_q <= zero_d;
                ovf_q  <= ovf_d;
                unf_q  <= unf_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign result    = res_q;
    assign flag_zero = zero_q;
    assign flag_ovf  = ovf_q;
    assign flag_unf  = unf_q;

endmodule

`default_nettype wire

// File: tb/tb_mant_addsub_normalize.sv
// ============================================================================
//  Module      : tb_mant_addsub_normalize
//  Description : Directed self-checking bench for mant_addsub_normalize.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mant_addsub_normalize;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        op_sub;
    logic        sign_a;
    logic        sign_b;
    logic [7:0]  exp_max;
    logic [23:0] al_man_a;
    logic [23:0] al_man_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        flag_zero;
    logic        flag_ovf;
    logic        flag_unf;

    int checks = 0;
    int errors = 0;

    mant_addsub_normalize dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_sub    (op_sub),
        .sign_a    (sign_a),
        .sign_b    (sign_b),
        .exp_max   (exp_max),
        .al_man_a  (al_man_a),
        .al_man_b  (al_man_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flag_zero (flag_zero),
        .flag_ovf  (flag_ovf),
        .flag_unf  (flag_unf)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic op, input logic sa, input logic sb,
                         input logic [7:0] e, input logic [23:0] a, input logic [23:0] b);
        op_sub   = op;
        sign_a   = sa;
        sign_b   = sb;
        exp_max  = e;
        al_man_a = a;
        al_man_b = b;
    endtask

    // Sends one beat into an empty pipe and returns the output and its latency
    task automatic run_one(input logic op, input logic sa, input logic sb,
                           input logic [7:0] e, input logic [23:0] a, input logic [23:0] b,
                           output logic [31:0] res, output logic [2:0] flg, output int lat);
        drive(op, sa, sb, e, a, b);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        res = result;
        flg = {flag_zero, flag_ovf, flag_unf};
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 8'd127, 24'h800000, 24'h800000);
        repeat (2) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h expected 00000000", result); end
        checks++; if ({flag_zero, flag_ovf, flag_unf} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {flag_zero, flag_ovf, flag_unf}); end
        rst = 1'b0; in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_no_ghost_beat: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_add_basic;
        logic [31:0] r; logic [2:0] f; int lat;
        run_one(1'b0, 1'b0, 1'b0, 8'd127, 24'h800000, 24'h800000, r, f, lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL add_latency: got %0d expected 3", lat); end
        checks++; if (r !== 32'h40000000) begin errors++; $display("FAIL add_result: got %h expected 40000000", r); end
        checks++; if (f !== 3'b000) begin errors++; $display("FAIL add_flags: got %b expected 000", f); end
    endtask

    task automatic test_sub_zero;
        logic [31:0] r; logic [2:0] f; int lat;
        run_one(1'b1, 1'b0, 1'b0, 8'd127, 24'h800000, 24'h800000, r, f, lat);
        checks++; if (r !== 32'h00000000) begin errors++; $display("FAIL sub_zero_result: got %h expected 00000000", r); end
        checks++; if (f !== 3'b100) begin errors++; $display("FAIL sub_zero_flags: got %b expected 100", f); end
        // Opposite signs on an add are an effective subtract; exact zero must be +0
        run_one(1'b0, 1'b1, 1'b0, 8'd127, 24'h800000, 24'h800000, r, f, lat);
        checks++; if (r !== 32'h00000000) begin errors++; $display("FAIL effsub_zero_result: got %h expected 00000000", r); end
        checks++; if (f !== 3'b100) begin errors++; $display("FAIL effsub_zero_flags: got %b expected 100", f); end
    endtask

    task automatic test_normalize_left;
        logic [31:0] r; logic [2:0] f; int lat;
        run_one(1'b1, 1'b0, 1'b0, 8'd127, 24'hC00000, 24'hA00000, r, f, lat);
        checks++; if (r !== 32'h3E800000) begin errors++; $display("FAIL norm_left_result: got %h expected 3e800000", r); end
        checks++; if (f !== 3'b000) begin errors++; $display("FAIL norm_left_flags: got %b expected 000", f); end
        run_one(1'b1, 1'b0, 1'b0, 8'd127, 24'hA00000, 24'hC00000, r, f, lat);
        checks++; if (r !== 32'hBE800000) begin errors++; $display("FAIL norm_neg_result: got %h expected be800000", r); end
    endtask

    task automatic test_overflow;
        logic [31:0] r; logic [2:0] f; int lat;
        run_one(1'b0, 1'b0, 1'b0, 8'd254, 24'hFFFFFF, 24'hFFFFFF, r, f, lat);
        checks++; if (r !== 32'h7F800000) begin errors++; $display("FAIL ovf_result: got %h expected 7f800000", r); end
        checks++; if (f !== 3'b010) begin errors++; $display("FAIL ovf_flags: got %b expected 010", f); end
    endtask

    task automatic test_underflow;
        logic [31:0] r; logic [2:0] f; int lat;
        run_one(1'b1, 1'b0, 1'b0, 8'd1, 24'hC00000, 24'h800000, r, f, lat);
        checks++; if (r !== 32'h00000000) begin errors++; $display("FAIL unf_edge_result: got %h expected 00000000", r); end
        checks++; if (f !== 3'b001) begin errors++; $display("FAIL unf_edge_flags: got %b expected 001", f); end
        run_one(1'b1, 1'b0, 1'b0, 8'd2, 24'hC00000, 24'h800000, r, f, lat);
        checks++; if (r !== 32'h00800000) begin errors++; $display("FAIL min_normal_result: got %h expected 00800000", r); end
        checks++; if (f !== 3'b000) begin errors++; $display("FAIL min_normal_flags: got %b expected 000", f); end
        run_one(1'b1, 1'b0, 1'b0, 8'd2, 24'h800000, 24'h7FFFFF, r, f, lat);
        checks++; if (f !== 3'b001) begin errors++; $display("FAIL unf_deep_flags: got %b expected 001", f); end
    endtask

    task automatic test_rounding;
        logic [31:0] r; logic [2:0] f; int lat;
        logic [31:0] exp_up;
`ifdef FP_ADD_ROUND_NEAREST_EN
        exp_up = 32'h40000002;
`else
        exp_up = 32'h40000001;
`endif
        run_one(1'b0, 1'b0, 1'b0, 8'd127, 24'h800003, 24'h800000, r, f, lat);
        checks++; if (r !== exp_up) begin errors++; $display("FAIL round_odd_result: got %h expected %h", r, exp_up); end
        run_one(1'b0, 1'b0, 1'b0, 8'd127, 24'h800001, 24'h800000, r, f, lat);
        checks++; if (r !== 32'h40000000) begin errors++; $display("FAIL round_tie_even_result: got %h expected 40000000", r); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp_r [4];
        int issued = 0, n = 0, first = -1, stalls = 0;
        for (int k = 0; k < 4; k++) exp_r[k] = {1'b0, 8'(50 + 10*k + 1), 23'd0};
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (out_valid) begin
                checks++; if (n >= 4 || result !== exp_r[n & 3]) begin errors++; $display("FAIL b2b_result[%0d]: got %h expected %h", n, result, exp_r[n & 3]); end
                if (n == 0) first = cyc;
                n++;
            end
            if (issued < 4) begin
                drive(1'b0, 1'b0, 1'b0, 8'(50 + 10*issued), 24'h800000, 24'h800000);
                in_valid = 1'b1;
                if (!in_ready) stalls++;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            if (in_valid && in_ready) issued++;
        end
        in_valid = 1'b0;
        checks++; if (n !== 4) begin errors++; $display("FAIL b2b_count: got %0d expected 4", n); end
        checks++; if (first !== 3) begin errors++; $display("FAIL b2b_first_cycle: got %0d expected 3", first); end
        checks++; if (stalls !== 0) begin errors++; $display("FAIL b2b_stalls: got %0d expected 0", stalls); end
    endtask

    task automatic test_backpressure;
        logic [31:0] exp_r [4];
        int acc = 0, n = 0;
        logic rdy;
        for (int k = 0; k < 4; k++) exp_r[k] = {1'b0, 8'(100 + 10*k + 1), 23'd0};
        out_ready = 1'b0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            drive(1'b0, 1'b0, 1'b0, 8'(100 + 10*acc), 24'h800000, 24'h800000);
            in_valid = 1'b1;
            rdy = in_ready;
            @(posedge clk); #1;
            if (rdy) acc++;
        end
        checks++; if (acc !== 3) begin errors++; $display("FAIL bp_accepted: got %0d expected 3", acc); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b expected 0", in_ready); end
        checks++; if (out_valid !== 1'b1 || result !== exp_r[0]) begin errors++; $display("FAIL bp_held_output: got %b/%h expected 1/%h", out_valid, result, exp_r[0]); end
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 20 && n < 4; cyc++) begin
            if (out_valid) begin
                checks++; if (result !== exp_r[n]) begin errors++; $display("FAIL bp_order[%0d]: got %h expected %h", n, result, exp_r[n]); end
                n++;
            end
            if (acc < 4) begin
                drive(1'b0, 1'b0, 1'b0, 8'(100 + 10*acc), 24'h800000, 24'h800000);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            rdy = in_ready;
            @(posedge clk); #1;
            if (rdy && in_valid) acc++;
        end
        in_valid = 1'b0;
        checks++; if (n !== 4) begin errors++; $display("FAIL bp_drained: got %0d expected 4", n); end
    endtask

    task automatic test_reset_midstream;
        int ghosts = 0;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0, 1'b0, 8'(20 + k), 24'h800000, 24'h800000);
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b expected 0", out_valid); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL midrst_result: got %h expected 00000000", result); end
        rst = 1'b0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(posedge clk); #1;
            if (out_valid) ghosts++;
        end
        checks++; if (ghosts !== 0) begin errors++; $display("FAIL midrst_stale_beats: got %0d expected 0", ghosts); end
    endtask

    initial begin
        in_valid = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 8'd0, 24'h0, 24'h0);
        test_reset();
        test_add_basic();
        test_sub_zero();
        test_normalize_left();
        test_overflow();
        test_underflow();
        test_rounding();
        test_back_to_back();
        test_backpressure();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
